// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the 8N1 UART slice: default bit timing, frame
// constants, the common four-state FSM encoding used by both the transmit
// and receive paths, and a helper that sizes the bit timer.
package uart_pkg;

  // Default bit period in clocks (100 MHz clock -> 1.5625 Mbaud).
  localparam int CLKS_PER_BIT_DEFAULT = 64;

  // Frame shape: eight data bits, LSB first, one stop bit at the idle level.
  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  // Both directions walk the same sequence of frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if
// Bundles the host-facing UART signals so the core and its user connect
// through one port.
//   tx_trig  host -> core  one-cycle transmit strobe
//   tx_data  host -> core  byte to send, sampled with tx_trig
//   rx       pins -> core  asynchronous serial input, idle high
//   tx       core -> pins  registered serial output, idle high
//   tx_busy  core -> host  high while a frame is being sent
//   rx_data  core -> host  last correctly received byte
//   po_flag  core -> host  one-cycle pulse when rx_data updates
// Modport master is the host/pin side; modport slave is the UART core.
interface uart_if;
  logic       tx_trig;
  logic [7:0] tx_data;
  logic       rx;
  logic       tx;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       po_flag;

  modport master (
    output tx_trig, tx_data, rx,
    input  tx, tx_busy, rx_data, po_flag
  );

  modport slave (
    input  tx_trig, tx_data, rx,
    output tx, tx_busy, rx_data, po_flag
  );
endinterface

// File: rtl/uart_rx_path.sv
// uart_rx_path
// 8N1 receiver. The asynchronous line is passed through a two-flop
// synchroniser, a falling edge starts a frame, the start bit is confirmed
// at mid-bit and data/stop bits are sampled at their centres. A good stop
// bit updates rx_data_o and pulses po_flag_o for one cycle.
//   clk, rstn   clock and asynchronous active-low reset
//   rx_i        asynchronous serial input, idle high
//   rx_data_o   last correctly received byte
//   po_flag_o   one-cycle pulse when rx_data_o updates
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       po_flag_o
);

  localparam int            CW        = cntWidth(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic          sync1_q, sync2_q;
  logic          rxs;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rxData_q, rxData_d;
  logic          flag_q, flag_d;
  logic          bitDone;

  // Two-flop synchroniser. Both stages reset to the idle level so that
  // leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rxs     = sync2_q;
  assign bitDone = (cnt_q == BIT_LAST);

  // State register, plus the registered outputs so po_flag is a clean pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      rxData_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      rxData_q <= rxData_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state logic. START waits half a bit to land in the middle of the
  // start bit; from there every full bit period is a mid-bit sample. Going
  // back to IDLE at mid-stop-bit leaves half a bit of slack for the next
  // frame's falling edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bitDone) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bitIdx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bitDone) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. Only a stop bit seen at the idle level publishes the
  // byte; a framing error leaves the previous byte in place.
  always_comb begin
    rxData_d = rxData_q;
    flag_d   = 1'b0;
    if (state_q == STOP && bitDone && rxs == STOP_LEVEL) begin
      rxData_d = shift_q;
      flag_d   = 1'b1;
    end
  end

  assign rx_data_o = rxData_q;
  assign po_flag_o = flag_q;

endmodule

// File: rtl/uart_tx_path.sv
// uart_tx_path
// 8N1 transmitter. A tx_trig_i strobe in IDLE latches tx_data_i and sends
// start bit, eight data bits LSB first and a stop bit, each CLKS_PER_BIT
// clocks long. Strobes arriving while a frame is in flight are ignored.
//   clk, rstn   clock and asynchronous active-low reset
//   tx_trig_i   start strobe
//   tx_data_i   byte to send
//   tx_o        registered serial output, idle high
//   tx_busy_o   high for the whole 10-bit frame
module uart_tx_path
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_trig_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_busy_o
);

  localparam int            CW       = cntWidth(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bitDone;

  assign bitDone = (cnt_q == BIT_LAST);

  // State register. The line level is registered alongside the state so
  // the pin never sees combinational glitches; reset parks it at idle high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  // Next-state logic. The bit timer runs 0..CLKS_PER_BIT-1 in every
  // non-idle phase; only IDLE looks at the strobe, which is what makes
  // strobes during a frame harmless.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        if (tx_trig_i) begin
          shift_d = tx_data_i;
          state_d = START;
        end
      end
      START: begin
        if (bitDone) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bitDone) begin
          cnt_d = '0;
          if (bitIdx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bitDone) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. The line level is decoded from the upcoming state so the
  // registered pin lines up exactly with the registered state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bitIdx_d];
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_core.sv
// uart_core
// Full-duplex 8N1 UART: an independent transmitter and receiver sharing
// one clock and reset. This level only wires the two paths to the bus.
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   uart_if slave modport (tx_trig/tx_data/rx in, tx/tx_busy/
//         rx_data/po_flag out)
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input logic   clk,
  input logic   rstn,
  uart_if.slave bus
);

  uart_tx_path #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .tx_trig_i (bus.tx_trig),
    .tx_data_i (bus.tx_data),
    .tx_o      (bus.tx),
    .tx_busy_o (bus.tx_busy)
  );

  uart_rx_path #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx_i      (bus.rx),
    .rx_data_o (bus.rx_data),
    .po_flag_o (bus.po_flag)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core
// Directed bench for uart_core at CLKS_PER_BIT=64 on a 100 MHz clock.
// The serial output is looped back into the receiver except where the
// bench drives rx itself to build glitches and malformed frames.
module tb_uart_core;

  localparam int CPB = 64;

  logic clk = 1'b0;
  logic rstn;
  logic loopback;
  logic rxDrive;

  int errCount   = 0;
  int checkCount = 0;
  int flagTotal  = 0;

  uart_if bus ();

  assign bus.rx = loopback ? bus.tx : rxDrive;

  uart_core #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Running count of receive pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.po_flag === 1'b1) flagTotal++;
  end

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Strobes one byte into the transmitter and watches 800 cycles after the
  // accepting edge. Sample i is taken at the negedge following edge i, so
  // the frame occupies samples 0..639. Optionally injects a second strobe
  // mid-frame or a reset mid-frame.
  task automatic applyStimulus(input logic [7:0] d, input bit watchWave,
                               input int intrudeAt, input int resetAt,
                               input int expectFlags, input logic [7:0] expectData);
    int         flags      = 0;
    int         busyCycles = 0;
    int         waveErrs   = 0;
    int         latency    = -1;
    logic [7:0] got        = 8'h00;
    logic       expTx;
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_trig = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i == 0) bus.tx_trig = 1'b0;
      if (i == intrudeAt) begin
        bus.tx_data = 8'h99;
        bus.tx_trig = 1'b1;
      end
      if (intrudeAt >= 0 && i == intrudeAt + 1) bus.tx_trig = 1'b0;
      if (i == resetAt) begin
        rstn = 1'b0;
        #1;
        checkOutput("reset_midframe_tx_high", {31'd0, bus.tx}, 32'd1);
        checkOutput("reset_midframe_busy_low", {31'd0, bus.tx_busy}, 32'd0);
      end
      if (resetAt >= 0 && i == resetAt + 10) rstn = 1'b1;
      if (bus.tx_busy === 1'b1) busyCycles++;
      if (bus.po_flag === 1'b1) begin
        flags++;
        latency = i;
        got     = bus.rx_data;
      end
      if (watchWave) begin
        if (i < CPB)            expTx = 1'b0;
        else if (i < 9 * CPB)   expTx = d[(i - CPB) / CPB];
        else                    expTx = 1'b1;
        if (bus.tx !== expTx) waveErrs++;
      end
    end
    checkOutput($sformatf("flag_cycles_%02h", d), flags, expectFlags);
    if (expectFlags == 1) begin
      checkOutput($sformatf("rx_data_%02h", d), {24'd0, got}, {24'd0, expectData});
      checkOutput($sformatf("latency_window_%02h_lat%0d", d, latency),
                  {31'd0, (latency >= 610 && latency <= 614)}, 32'd1);
    end
    if (resetAt < 0) checkOutput($sformatf("busy_cycles_%02h", d), busyCycles, 10 * CPB);
    if (watchWave) checkOutput($sformatf("tx_waveform_%02h", d), waveErrs, 0);
  endtask

  // Drives one hand-built frame onto rx with a chosen stop-bit level.
  task automatic driveRxFrame(input logic [7:0] d, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      rxDrive = frame[b];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rxDrive = 1'b1;
  endtask

  initial begin
    int base;
    rstn        = 1'b0;
    loopback    = 1'b1;
    rxDrive     = 1'b1;
    bus.tx_trig = 1'b0;
    bus.tx_data = 8'h00;

    // Reset values while reset is held.
    #100;
    checkOutput("reset_tx", {31'd0, bus.tx}, 32'd1);
    checkOutput("reset_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    checkOutput("reset_po_flag", {31'd0, bus.po_flag}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback sequence; 0xA3 also gets a cycle-by-cycle waveform check.
    applyStimulus(8'h55, 1'b0, -1, -1, 1, 8'h55);
    applyStimulus(8'hA3, 1'b1, -1, -1, 1, 8'hA3);
    applyStimulus(8'h00, 1'b0, -1, -1, 1, 8'h00);
    applyStimulus(8'hFF, 1'b1, -1, -1, 1, 8'hFF);
    checkOutput("loopback_total_flags", flagTotal, 4);

    // Strobe during a frame must be ignored.
    applyStimulus(8'h3C, 1'b1, 100, -1, 1, 8'h3C);
    base = flagTotal;
    repeat (800) @(negedge clk);
    checkOutput("busy_reject_no_second_frame", flagTotal - base, 0);
    checkOutput("busy_reject_idle", {31'd0, bus.tx_busy}, 32'd0);

    // Receiver robustness with rx driven directly.
    loopback = 1'b0;
    rxDrive  = 1'b1;
    repeat (20) @(negedge clk);
    base = flagTotal;
    rxDrive = 1'b0;
    repeat (20) @(negedge clk);
    rxDrive = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("glitch_no_flag", flagTotal - base, 0);

    driveRxFrame(8'h5A, 1'b0);
    repeat (200) @(negedge clk);
    checkOutput("framing_error_no_flag", flagTotal - base, 0);
    checkOutput("framing_error_rx_data_kept", {24'd0, bus.rx_data}, 32'h3C);

    driveRxFrame(8'hC6, 1'b1);
    repeat (200) @(negedge clk);
    checkOutput("external_frame_flag", flagTotal - base, 1);
    checkOutput("external_frame_rx_data", {24'd0, bus.rx_data}, 32'hC6);

    // Reset in the middle of a looped-back frame, then recovery.
    loopback = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(8'h81, 1'b0, -1, 300, 0, 8'h00);
    checkOutput("reset_midframe_rx_data_cleared", {24'd0, bus.rx_data}, 32'd0);
    applyStimulus(8'h42, 1'b1, -1, -1, 1, 8'h42);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
